// File: rtl/ss_disp_ctrl.sv
// ss_disp_ctrl: converts a saturated binary millisecond count into six BCD
// digits with an iterative double-dabble. It then time-shares one external
// seven-segment decoder across HEX0..HEX5, one digit per cycle. Leading zeros
// above the decimal point can be blanked.
module ss_disp_ctrl #(
  parameter int unsigned DP_POS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [19:0] value,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [4:0]  seg_code,
  input  logic [7:0]  seg_in,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam logic [4:0]  DP_K     = 5'(DP_POS);
  localparam logic [4:0]  LAST_BIT = 5'd19;
  localparam logic [4:0]  LAST_DIG = 5'd5;
  localparam logic [19:0] VMAX     = 20'd999999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DECODE
  } state_t;

  // Clamp the input count to the largest six-digit decimal value.
  function automatic logic [19:0] sat_value(input logic [19:0] v);
    return (v > VMAX) ? VMAX : v;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [23:0] dd_adjust(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [7:0]  hex_q [6];
  logic [7:0]  hex_d;
  logic [43:0] dd_next;
  logic [23:0] bcd_sh;
  logic        blank;

  // Next-state logic: load capture, one conversion bit per cycle, then one digit per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    dd_next = {dd_adjust(bcd_q), bin_q} << 1;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_CONVERT;
          cnt_d   = 5'd0;
          bin_d   = sat_value(value);
          bcd_d   = 24'd0;
          ovf_d   = (value > VMAX);
        end
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = dd_next;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DECODE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DECODE: begin
        if (cnt_q == LAST_DIG) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Current digit selection, decoder drive and leading-zero blanking decision.
  always_comb begin
    bcd_sh   = bcd_q >> {cnt_q, 2'b00};
    blank    = BLANK_LZ && (cnt_q > DP_K) && (bcd_sh == 24'd0);
    hex_d    = blank ? 8'hFF : seg_in;
    seg_code = (state_q == S_DECODE) ? {cnt_q == DP_K, bcd_sh[3:0]} : 5'b00000;
  end

  // Control state: sequencer, counter, overflow flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Conversion datapath: binary shift register and BCD accumulator.
  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  // Per-digit segment registers; only the digit being decoded is written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        hex_q[i] <= 8'hFF;
      end else if (state_q == S_DECODE && cnt_q == 5'(i)) begin
        hex_q[i] <= hex_d;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: doc/ss_disp_ctrl.md
# ss_disp_ctrl

Sequencer that converts a binary millisecond count from the reaction-timer datapath into six BCD digits and time-shares one external seven-segment decoder (5-bit code in, 8-bit active-low segments out, code bit 4 = decimal point) across display digits HEX0..HEX5. It registers each decoded pattern into a per-digit output register, applies leading-zero blanking and a fixed decimal-point position, and reports completion with a done pulse. It sits between the timer counter and the board HEX pins.

## Interface

Parameters:
- DP_POS, 3, digit index (0..5) that shows the decimal point; 6 means no decimal point.
- BLANK_LZ, 1, 1 blanks leading zeros above DP_POS; 0 shows all digits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  start strobe; sampled only in IDLE.
- value  in  20  unsigned binary count (ms); values above 999999 saturate.
- busy  out  1  high while a conversion/decode sequence is running.
- done  out  1  one-cycle pulse when all six hex registers are updated.
- ovf  out  1  set when the last loaded value exceeded 999999; held until next load.
- seg_code  out  5  to the shared decoder input: bit 4 = DP, bits 3:0 = BCD digit.
- seg_in  in  8  from the shared decoder output; active-low, bit 7 = DP.
- hex0..hex5  out  8 each  registered active-low segment patterns; hex0 is least significant.

## Operation

- States: IDLE, CONVERT, DECODE.
- IDLE: busy=0. On load=1, capture min(value, 999999) into the shift register, clear the 24-bit BCD register, set ovf = (value > 999999), and go to CONVERT.
- CONVERT: iterative double-dabble, one bit per cycle for 20 cycles. Each cycle, first add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by one. After the 20th cycle, go to DECODE with digit index k=0.
- DECODE: one digit per cycle, k=0..5.
  - seg_code = {k==DP_POS, bcd[4k+3:4k]}.
  - seg_in is captured into hexk at the end of the cycle. The decoder is combinational; no wait cycle.
  - Blanking: if BLANK_LZ=1, k>DP_POS, and BCD digits k..5 are all zero, hexk = 8'hFF instead of seg_in. seg_code is still driven.
  - After k=5, go to IDLE and pulse done.
- seg_code = 5'b00000 outside DECODE.
- hex registers hold their values between sequences; only DECODE writes them.
- load while busy is ignored. It is not queued.

## Timing

- Reset values: busy=0, done=0, ovf=0, seg_code=0, hex0..hex5=8'hFF (all segments off). The state machine goes to IDLE.
- Let load be sampled at edge E:
  - busy=1 from E through the cycle ending at E+26.
  - CONVERT spans the cycles ending at E+1..E+20.
  - hexk is written at edge E+21+k.
  - done=1 and busy=0 in the cycle after E+26 (one cycle only).
- load asserted during the done cycle is accepted; the state is already IDLE.
- Reset in any state aborts the sequence. Partial BCD is discarded, and hex registers return to 8'hFF on the next edge.
- value is sampled only at the accepting edge; later changes have no effect.
- Back-to-back sequences: minimum period 27 cycles, load edge to load edge.

## Test plan

- Reset: assert rst 2 cycles with random prior state -> hex0..hex5=8'hFF, busy=0, done=0, ovf=0, seg_code=0.
- value=1234, defaults -> done exactly 27 cycles after load edge; hex0=8'h99, hex1=8'hB0, hex2=8'hA4, hex3=8'h79, hex4=8'hFF, hex5=8'hFF, ovf=0.
- value=0, defaults -> hex0=hex1=hex2=8'hC0, hex3=8'h40, hex4=hex5=8'hFF; separately with BLANK_LZ=0 -> hex4=hex5=8'hC0.
- value=1000000 -> ovf=1; hex0,1,2,4,5=8'h98, hex3=8'h18 (999.999 displayed).
- value=5 loaded, second load (value=7) pulsed at cycle 10 of busy -> ignored; result shows 5 (hex0=8'h92). Load of 7 in the done cycle -> accepted; 27 cycles later hex0=8'hF8.
- rst asserted at cycle 12 of CONVERT -> next cycle busy=0, all hex=8'hFF, no done pulse. A subsequent load of 42 completes normally: hex0=8'h99, hex1=8'hA4.
